// File: rtl/filter_pkg.sv
// Shared types for the multichannel resonant filter: mode and FSM encodings,
// per-channel state record and a width-generic saturating clamp.
package filter_pkg;

   localparam int FILT_STATE_W = 32;
   localparam int FILT_COEF_W  = 16;

   typedef enum logic [1:0] {
      FILT_LP = 2'd0,
      FILT_BP = 2'd1,
      FILT_HP = 2'd2
   } filt_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2
   } filt_state_t;

   typedef struct packed {
      logic signed [FILT_STATE_W-1:0] z1;
      logic signed [FILT_STATE_W-1:0] z2;
   } chan_state_t;

   // Clamp a sign-extended value into the signed range of w bits (w <= 63).
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/filter_state_bank.sv
// Per-channel {z1, z2} register bank: one combinational read port, one write
// port, single-channel clear and synchronous clear-all on reset.
module filter_state_bank
   import filter_pkg::*;
#(
   parameter int N_CHANNELS = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [$clog2(N_CHANNELS)-1:0] rd_addr,
   output chan_state_t                   rd_data,
   input  logic                          wr_en,
   input  logic [$clog2(N_CHANNELS)-1:0] wr_addr,
   input  chan_state_t                   wr_data,
   input  logic                          clr_en,
   input  logic [$clog2(N_CHANNELS)-1:0] clr_addr
);

   chan_state_t bank [N_CHANNELS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_CHANNELS; i++) bank[i] <= '0;
      end else begin
         if (clr_en) bank[clr_addr] <= '0;
         if (wr_en)  bank[wr_addr]  <= wr_data;
      end
   end

   assign rd_data = bank[rd_addr];

endmodule

// File: rtl/multichannel_resonant_filter.sv
// Time-multiplexed resonant filter (LP/BP/HP) shared by N_CHANNELS voices.
// Optional per-channel state clear port: define FILTER_CHANNEL_CLEAR_EN.
//
// state   | meaning
// ST_IDLE | in_ready high; accept latches operands and the channel's z1/z2
// ST_MUL  | coefficient and input products formed, registered at exit
// ST_ACC  | accumulate/saturate, write z1/z2 back, register output strobe
module multichannel_resonant_filter
   import filter_pkg::*;
#(
   parameter int N_CHANNELS = 16,
   parameter int SAMPLE_W   = 16,
   parameter int STATE_W    = FILT_STATE_W,
   parameter int Q_W        = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [$clog2(N_CHANNELS)-1:0] in_channel,
   input  logic [SAMPLE_W-1:0]           in_sample,
   input  logic [SAMPLE_W-1:0]           in_sine,
   input  logic [Q_W-1:0]                cfg_q,
   input  logic                          cfg_on,
   input  logic [1:0]                    cfg_mode,
`ifdef FILTER_CHANNEL_CLEAR_EN
   input  logic                          clear_valid,
   input  logic [$clog2(N_CHANNELS)-1:0] clear_channel,
`endif
   output logic                          out_valid,
   output logic [$clog2(N_CHANNELS)-1:0] out_channel,
   output logic [SAMPLE_W-1:0]           out_sample
);

   localparam int CH_W = $clog2(N_CHANNELS);
   localparam int D_W  = FILT_COEF_W;
   localparam int CP_W = SAMPLE_W + Q_W + 1;
   localparam int XW   = STATE_W + 2;
   localparam int HW   = SAMPLE_W + 1;

   filt_state_t                 state;
   logic [CH_W-1:0]             ch_r;
   logic signed [SAMPLE_W-1:0]  x_r;
   logic signed [SAMPLE_W-1:0]  sine_r;
   logic [Q_W-1:0]              q_r;
   logic                        on_r;
   logic [1:0]                  mode_r;
   logic signed [STATE_W-1:0]   z1_r;
   logic signed [STATE_W-1:0]   z2_r;
   logic [D_W-1:0]              d_r;
   logic signed [SAMPLE_W-1:0]  c_r;
   logic signed [STATE_W-1:0]   xk_r;
   logic signed [STATE_W-1:0]   xd_r;

   logic                        accept;
   logic                        clr_en;
   logic [CH_W-1:0]             clr_addr;
   logic                        clr_hit;
   chan_state_t                 rd_state;
   chan_state_t                 wr_state;
   logic                        wr_en;

   assign in_ready = (state == ST_IDLE) && !reset;
   assign accept   = in_valid && in_ready;

`ifdef FILTER_CHANNEL_CLEAR_EN
   assign clr_en   = clear_valid && (state == ST_IDLE);
   assign clr_addr = clear_channel;
`else
   assign clr_en   = 1'b0;
   assign clr_addr = '0;
`endif
   // A clear landing on the channel being accepted must be seen by that sample.
   assign clr_hit = clr_en && (clr_addr == in_channel);

   // MUL stage: coefficients and input products
   logic [D_W-1:0]             q_ext;
   logic [D_W-1:0]             d_c;
   logic [D_W-1:0]             k_c;
   logic signed [Q_W:0]        q_s;
   logic signed [CP_W-1:0]     c_prod;
   logic signed [SAMPLE_W-1:0] c_c;
   logic signed [D_W:0]        k_s;
   logic signed [D_W:0]        d_s;
   logic signed [STATE_W-1:0]  xk_c;
   logic signed [STATE_W-1:0]  xd_c;

   always_comb begin
      q_ext  = D_W'(q_r);
      d_c    = q_ext * q_ext;
      k_c    = (~d_c) >> 1;
      q_s    = signed'({1'b0, q_r});
      c_prod = CP_W'(sine_r) * CP_W'(q_s);
      c_c    = SAMPLE_W'(c_prod >>> Q_W);
      k_s    = signed'({1'b0, k_c});
      d_s    = signed'({1'b0, d_c});
      xk_c   = STATE_W'(x_r) * STATE_W'(k_s);
      xd_c   = STATE_W'(x_r) * STATE_W'(d_s);
   end

   // ACC stage: sums are formed two bits wide so the clamp never sees a wrap
   logic signed [D_W:0]        d_rs;
   logic signed [XW-1:0]       y_sum;
   logic signed [STATE_W-1:0]  y_c;
   logic signed [SAMPLE_W-1:0] yh;
   logic signed [STATE_W-1:0]  cy;
   logic signed [XW-1:0]       z1_sum;
   logic signed [XW-1:0]       yd;
   logic signed [XW-1:0]       z2_sum;
   logic signed [STATE_W-1:0]  z1_n;
   logic signed [STATE_W-1:0]  z2_n;
   logic signed [HW-1:0]       hp_sum;
   logic signed [SAMPLE_W-1:0] hp_c;
   logic signed [SAMPLE_W-1:0] res;

   always_comb begin
      d_rs   = signed'({1'b0, d_r});
      y_sum  = XW'(z1_r) + XW'(xk_r);
      y_c    = STATE_W'(saturate(64'(y_sum), STATE_W));
      yh     = SAMPLE_W'(y_c >>> (STATE_W - SAMPLE_W));
      cy     = STATE_W'(c_r) * STATE_W'(yh);
      z1_sum = XW'(z2_r) + (XW'(cy) <<< 1);
      z1_n   = STATE_W'(saturate(64'(z1_sum), STATE_W));
      yd     = XW'(yh) * XW'(d_rs);
      z2_sum = XW'(xd_r) - yd;
      z2_n   = STATE_W'(saturate(64'(z2_sum), STATE_W));
      hp_sum = HW'(x_r) - HW'(yh);
      hp_c   = SAMPLE_W'(saturate(64'(hp_sum), SAMPLE_W));
      case (mode_r)
         FILT_BP: res = SAMPLE_W'(z1_n >>> (STATE_W - SAMPLE_W));
         FILT_HP: res = hp_c;
         default: res = yh;
      endcase
   end

   assign wr_en       = (state == ST_ACC) && on_r;
   assign wr_state.z1 = z1_n;
   assign wr_state.z2 = z2_n;

   filter_state_bank #(
      .N_CHANNELS (N_CHANNELS)
   ) u_bank (
      .clock    (clock),
      .reset    (reset),
      .rd_addr  (in_channel),
      .rd_data  (rd_state),
      .wr_en    (wr_en),
      .wr_addr  (ch_r),
      .wr_data  (wr_state),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         out_valid   <= 1'b0;
         out_sample  <= '0;
         out_channel <= '0;
         ch_r        <= '0;
         x_r         <= '0;
         sine_r      <= '0;
         q_r         <= '0;
         on_r        <= 1'b0;
         mode_r      <= '0;
         z1_r        <= '0;
         z2_r        <= '0;
         d_r         <= '0;
         c_r         <= '0;
         xk_r        <= '0;
         xd_r        <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  ch_r   <= in_channel;
                  x_r    <= in_sample;
                  sine_r <= in_sine;
                  q_r    <= cfg_q;
                  on_r   <= cfg_on;
                  mode_r <= cfg_mode;
                  z1_r   <= clr_hit ? '0 : rd_state.z1;
                  z2_r   <= clr_hit ? '0 : rd_state.z2;
                  state  <= ST_MUL;
               end
            end
            ST_MUL: begin
               d_r   <= d_c;
               c_r   <= c_c;
               xk_r  <= xk_c;
               xd_r  <= xd_c;
               state <= ST_ACC;
            end
            ST_ACC: begin
               out_valid   <= 1'b1;
               out_channel <= ch_r;
               out_sample  <= on_r ? res : x_r;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multichannel_resonant_filter.sv
// Self-checking bench for multichannel_resonant_filter: vector table, corner
// sequences and random traffic against an arithmetic reference model.
module tb_multichannel_resonant_filter;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_channel;
   logic [15:0] in_sample;
   logic [15:0] in_sine;
   logic [7:0]  cfg_q;
   logic        cfg_on;
   logic [1:0]  cfg_mode;
`ifdef FILTER_CHANNEL_CLEAR_EN
   logic        clear_valid;
   logic [3:0]  clear_channel;
`endif
   logic        out_valid;
   logic [3:0]  out_channel;
   logic [15:0] out_sample;

   always #5 clock = ~clock;

   multichannel_resonant_filter dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_channel    (in_channel),
      .in_sample     (in_sample),
      .in_sine       (in_sine),
      .cfg_q         (cfg_q),
      .cfg_on        (cfg_on),
      .cfg_mode      (cfg_mode),
`ifdef FILTER_CHANNEL_CLEAR_EN
      .clear_valid   (clear_valid),
      .clear_channel (clear_channel),
`endif
      .out_valid     (out_valid),
      .out_channel   (out_channel),
      .out_sample    (out_sample)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic over per-channel state arrays.
   longint mz1 [16];
   longint mz2 [16];

   function automatic longint m_sat(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint wrap16(input longint v);
      longint t;
      t = v & 64'hFFFF;
      if (t >= 32768) t = t - 65536;
      return t;
   endfunction

   function automatic logic [15:0] model_step(input int ch, input logic [15:0] x16,
         input logic [15:0] s16, input logic [7:0] q8, input logic on, input logic [1:0] mode);
      longint x, s, q, d, k, c, y, yh, z1n, z2n, o;
      if (!on) return x16;
      x   = longint'($signed(x16));
      s   = longint'($signed(s16));
      q   = longint'(q8);
      d   = (q * q) & 64'hFFFF;
      k   = ((~d) & 64'hFFFF) >> 1;
      c   = wrap16((s * q) >>> 8);
      y   = m_sat(mz1[ch] + x * k, 32);
      yh  = y >>> 16;
      z1n = m_sat(mz2[ch] + 2 * c * yh, 32);
      z2n = m_sat(x * d - yh * d, 32);
      mz1[ch] = z1n;
      mz2[ch] = z2n;
      case (mode)
         2'd1:    o = z1n >>> 16;
         2'd2:    o = m_sat(x - yh, 16);
         default: o = yh;
      endcase
      return 16'(o);
   endfunction

   task automatic run_sample(input logic [3:0] ch, input logic [15:0] x, input logic [15:0] s,
         input logic [7:0] q, input logic on, input logic [1:0] mode, input bit clr,
         output logic [15:0] got);
      int n;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 10) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_channel = ch;
      in_sample  = x;
      in_sine    = s;
      cfg_q      = q;
      cfg_on     = on;
      cfg_mode   = mode;
      in_valid   = 1'b1;
`ifdef FILTER_CHANNEL_CLEAR_EN
      clear_valid   = clr;
      clear_channel = ch;
`else
      if (clr) $display("note: clear request ignored in this build");
`endif
      @(posedge clock);
      #1;
      in_valid   = 1'b0;
`ifdef FILTER_CHANNEL_CLEAR_EN
      clear_valid = 1'b0;
`endif
      in_channel = 4'($urandom);
      in_sample  = 16'($urandom);
      in_sine    = 16'($urandom);
      cfg_q      = 8'($urandom);
      cfg_on     = 1'($urandom);
      cfg_mode   = 2'($urandom);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         if (c < 3) begin
            chk("busy_ready", {31'd0, in_ready}, 32'd0);
            chk("busy_valid", {31'd0, out_valid}, 32'd0);
         end
      end
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_channel", {28'd0, out_channel}, {28'd0, ch});
      chk("ready_after", {31'd0, in_ready}, 32'd1);
      got = out_sample;
      @(negedge clock);
      chk("strobe_len", {31'd0, out_valid}, 32'd0);
      chk("out_hold", {16'd0, out_sample}, {16'd0, got});
   endtask

   typedef struct {
      logic [3:0]  ch;
      logic [15:0] x;
      logic [15:0] s;
      logic [7:0]  q;
      logic        on;
      logic [1:0]  mode;
      logic [15:0] exp;
   } vec_t;

   vec_t vt [15];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got;
      logic [15:0] expv;
      logic [15:0] prev;
      bit          have_prev;

      vt[0]  = '{4'd3,  16'h1234, 16'h0000, 8'h00, 1'b0, 2'd0, 16'h1234};
      vt[1]  = '{4'd0,  16'h4000, 16'h0000, 8'h00, 1'b1, 2'd0, 16'h1FFF};
      vt[2]  = '{4'd0,  16'h4000, 16'h0000, 8'h00, 1'b1, 2'd0, 16'h1FFF};
      vt[3]  = '{4'd0,  16'h4000, 16'h0000, 8'h00, 1'b1, 2'd0, 16'h1FFF};
      vt[4]  = '{4'd0,  16'h4000, 16'h0000, 8'h00, 1'b1, 2'd0, 16'h1FFF};
      vt[5]  = '{4'd6,  16'hC000, 16'h1111, 8'h00, 1'b1, 2'd0, 16'hE000};
      vt[6]  = '{4'd7,  16'h4000, 16'h2345, 8'h00, 1'b1, 2'd2, 16'h2001};
      vt[7]  = '{4'd0,  16'h4000, 16'h0000, 8'h00, 1'b1, 2'd1, 16'h0000};
      vt[8]  = '{4'd0,  16'h4000, 16'h0000, 8'h00, 1'b1, 2'd3, 16'h1FFF};
      vt[9]  = '{4'd15, 16'h8000, 16'h7FFF, 8'hFF, 1'b0, 2'd1, 16'h8000};
      vt[10] = '{4'd8,  16'h4000, 16'h0000, 8'h80, 1'b1, 2'd0, 16'h17FF};
      vt[11] = '{4'd8,  16'h4000, 16'h0000, 8'h80, 1'b1, 2'd1, 16'h0A00};
      vt[12] = '{4'd8,  16'h4000, 16'h0000, 8'h80, 1'b1, 2'd0, 16'h2200};
      vt[13] = '{4'd9,  16'h7FFF, 16'h4000, 8'h90, 1'b0, 2'd2, 16'h7FFF};
      vt[14] = '{4'd9,  16'h4000, 16'h0000, 8'h00, 1'b1, 2'd0, 16'h1FFF};

      for (int i = 0; i < 16; i++) begin
         mz1[i] = 0;
         mz2[i] = 0;
      end
      reset = 1'b1; in_valid = 1'b0; in_channel = '0; in_sample = '0; in_sine = '0;
      cfg_q = '0; cfg_on = 1'b0; cfg_mode = '0;
`ifdef FILTER_CHANNEL_CLEAR_EN
      clear_valid = 1'b0; clear_channel = '0;
`endif
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sample", {16'd0, out_sample}, 32'd0);
      chk("rst_channel", {28'd0, out_channel}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("ready_idle", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 15; i++) begin
         expv = model_step(vt[i].ch, vt[i].x, vt[i].s, vt[i].q, vt[i].on, vt[i].mode);
         run_sample(vt[i].ch, vt[i].x, vt[i].s, vt[i].q, vt[i].on, vt[i].mode, 1'b0, got);
         chk($sformatf("vec%0d", i), {16'd0, got}, {16'd0, vt[i].exp});
         chk($sformatf("vec%0d_model", i), {16'd0, expv}, {16'd0, vt[i].exp});
      end

      // Saturation: long constant-input runs at both extremes
      for (int run = 0; run < 2; run++) begin
         have_prev = 1'b0;
         prev = '0;
         for (int i = 0; i < 64; i++) begin
            logic [15:0] xv;
            xv = (run == 0) ? 16'h7FFF : 16'h8000;
            expv = model_step(1, xv, 16'h7FFF, 8'hFF, 1'b1, 2'd0);
            run_sample(4'd1, xv, 16'h7FFF, 8'hFF, 1'b1, 2'd0, 1'b0, got);
            chk("sat_model", {16'd0, got}, {16'd0, expv});
            if (have_prev) begin
               chk("sat_noflip",
                   {31'd0, ((prev == 16'h7FFF) && got[15]) || ((prev == 16'h8000) && !got[15])},
                   32'd0);
            end
            prev = got;
            have_prev = 1'b1;
         end
         chk("sat_clamp", {16'd0, prev}, (run == 0) ? 32'h7FFF : 32'h8000);
      end

      // Isolation: ch5 idles at zero while ch0 resonates
      for (int i = 0; i < 8; i++) begin
         expv = model_step(0, 16'h7000, 16'h3000, 8'hC0, 1'b1, 2'd1);
         run_sample(4'd0, 16'h7000, 16'h3000, 8'hC0, 1'b1, 2'd1, 1'b0, got);
         chk("iso_ch0", {16'd0, got}, {16'd0, expv});
         expv = model_step(5, 16'h0000, 16'h3000, 8'hC0, 1'b1, 2'd1);
         run_sample(4'd5, 16'h0000, 16'h3000, 8'hC0, 1'b1, 2'd1, 1'b0, got);
         chk("iso_ch5", {16'd0, got}, 32'd0);
      end

      for (int i = 0; i < 60; i++) begin
         logic [3:0]  ch;
         logic [15:0] xv, sv;
         logic [7:0]  qv;
         logic        onv;
         logic [1:0]  mv;
         ch  = 4'($urandom_range(0, 15));
         xv  = 16'($urandom);
         sv  = 16'($urandom);
         qv  = 8'($urandom);
         onv = ($urandom_range(0, 3) != 0);
         mv  = 2'($urandom_range(0, 3));
         expv = model_step(int'(ch), xv, sv, qv, onv, mv);
         run_sample(ch, xv, sv, qv, onv, mv, 1'b0, got);
         chk($sformatf("rand%0d", i), {16'd0, got}, {16'd0, expv});
      end

      // Reset while the accepted sample sits in MUL
      @(negedge clock);
      in_channel = 4'd2; in_sample = 16'h4000; in_sine = 16'h0000;
      cfg_q = 8'h40; cfg_on = 1'b1; cfg_mode = 2'd0; in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1 chk("midrst_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      chk("midrst_sample", {16'd0, out_sample}, 32'd0);
      chk("midrst_channel", {28'd0, out_channel}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("midrst_novalid", {31'd0, out_valid}, 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         mz1[i] = 0;
         mz2[i] = 0;
      end
      run_sample(4'd2, 16'h0000, 16'h0000, 8'h00, 1'b1, 2'd0, 1'b0, got);
      chk("postrst_ch2", {16'd0, got}, 32'd0);
      run_sample(4'd8, 16'h4000, 16'h0000, 8'h00, 1'b1, 2'd0, 1'b0, got);
      chk("postrst_ch8", {16'd0, got}, 32'h1FFF);

`ifdef FILTER_CHANNEL_CLEAR_EN
      run_sample(4'd4, 16'h4000, 16'h0000, 8'h80, 1'b1, 2'd0, 1'b0, got);
      chk("prime1", {16'd0, got}, 32'h17FF);
      run_sample(4'd4, 16'h4000, 16'h0000, 8'h80, 1'b1, 2'd0, 1'b0, got);
      chk("prime2", {16'd0, got}, 32'h17FF);
      run_sample(4'd4, 16'h4000, 16'h0000, 8'h00, 1'b1, 2'd0, 1'b1, got);
      chk("clear_same_cycle", {16'd0, got}, 32'h1FFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
